// File: rtl/march_bist_ctrl.sv
// March C- memory BIST engine.
// Drives a memory with registered write data (captured one cycle before the
// write edge) and a 2-cycle read latency. Runs
//   e0 up(w0); e1 up(r0,w1); e2 up(r1,w0); e3 dn(r0,w1); e4 dn(r1,w0); e5 up(r0)
// and reports pass/fail, the first failing address/element and a saturating
// miscompare count.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             run request, honoured only in IDLE/DONE
//   mem_write_read    1 = write, 0 = read
//   mem_address       memory address
//   mem_wdata         data of the op issued in the following cycle
//   mem_rdata         memory read data (2 cycles after the read is issued)
//   busy / done       RUN or DRAIN / test finished
//   fail              sticky miscompare flag for the current run
//   fail_addr/elem    location and element index of the first miscompare
//   fail_count        miscompare count, saturating at 255
//
// state | meaning
// IDLE  | waiting for first start
// RUN   | issuing one memory op per cycle
// DRAIN | waiting for the last two reads to return
// DONE  | results valid, waiting for start
module march_bist_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CAPACITY   = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  mem_write_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [7:0]            fail_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(CAPACITY);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] ONES     = '1;

    // Position of one op in the march: element, address, op index within element.
    typedef struct packed {
        logic [2:0]            elem;
        logic [ADDR_WIDTH-1:0] addr;
        logic                  phase;
    } pos_t;

    function automatic logic is_desc(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic two_ops(input logic [2:0] e);
        return (e >= 3'd1) && (e <= 3'd4);
    endfunction

    function automatic logic op_is_write(input pos_t p);
        return (p.elem == 3'd0) || p.phase;
    endfunction

    // Write data for writes, expected data for reads.
    function automatic logic [DATA_WIDTH-1:0] op_data(input pos_t p);
        logic [DATA_WIDTH-1:0] d;
        case (p.elem)
            3'd1, 3'd3: d = p.phase ? ONES : '0;
            3'd2, 3'd4: d = p.phase ? '0 : ONES;
            default:    d = '0;
        endcase
        return d;
    endfunction

    function automatic logic is_final(input pos_t p);
        return (p.elem == 3'd5) && (p.addr == ADDR_MAX);
    endfunction

    function automatic pos_t advance(input pos_t p);
        pos_t n;
        n = p;
        if (two_ops(p.elem) && !p.phase) begin
            n.phase = 1'b1;
        end else begin
            n.phase = 1'b0;
            if (p.addr == (is_desc(p.elem) ? '0 : ADDR_MAX)) begin
                n.elem = p.elem + 3'd1;
                n.addr = is_desc(n.elem) ? ADDR_MAX : '0;
            end else begin
                n.addr = is_desc(p.elem) ? p.addr - ADDR_ONE : p.addr + ADDR_ONE;
            end
        end
        return n;
    endfunction

    logic [1:0]            state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] cur_exp_q, cur_exp_d;
    logic [2:0]            cur_elem_q, cur_elem_d;
    pos_t                  la_q, la_d;          // op to issue next cycle
    logic                  la_valid_q, la_valid_d;
    logic                  drain_q, drain_d;
    logic                  start_acc;
    pos_t                  la_next;
    pos_t                  first_next;

    logic                  s1_valid_q, s2_valid_q;
    logic [DATA_WIDTH-1:0] s1_exp_q, s2_exp_q;
    logic [ADDR_WIDTH-1:0] s1_addr_q, s2_addr_q;
    logic [2:0]            s1_elem_q, s2_elem_q;
    logic                  fail_q;
    logic [ADDR_WIDTH-1:0] fail_addr_q;
    logic [2:0]            fail_elem_q;
    logic [7:0]            fail_count_q;
    logic                  miscompare;

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cur_exp_d  = cur_exp_q;
        cur_elem_d = cur_elem_q;
        la_d       = la_q;
        la_valid_d = la_valid_q;
        drain_d    = drain_q;
        start_acc  = 1'b0;
        la_next    = advance(la_q);
        first_next = advance(pos_t'('0));
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_acc  = 1'b1;
                    state_d    = S_RUN;
                    we_d       = 1'b1;
                    addr_d     = '0;
                    cur_exp_d  = '0;
                    cur_elem_d = 3'd0;
                    la_d       = first_next;
                    la_valid_d = 1'b1;
                    wdata_d    = op_data(first_next);
                end
            end
            S_RUN: begin
                if (la_valid_q) begin
                    we_d       = op_is_write(la_q);
                    addr_d     = la_q.addr;
                    cur_exp_d  = op_data(la_q);
                    cur_elem_d = la_q.elem;
                    la_d       = la_next;
                    la_valid_d = !is_final(la_q);
                    // wdata leads the issued op by one cycle
                    wdata_d    = is_final(la_q) ? '0 : op_data(la_next);
                end else begin
                    state_d = S_DRAIN;
                    we_d    = 1'b0;
                    wdata_d = '0;
                    drain_d = 1'b0;
                end
            end
            S_DRAIN: begin
                if (drain_q) state_d = S_DONE;
                else         drain_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cur_exp_q  <= '0;
            cur_elem_q <= 3'd0;
            la_q       <= '0;
            la_valid_q <= 1'b0;
            drain_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cur_exp_q  <= cur_exp_d;
            cur_elem_q <= cur_elem_d;
            la_q       <= la_d;
            la_valid_q <= la_valid_d;
            drain_q    <= drain_d;
        end
    end

    assign miscompare = s2_valid_q && (mem_rdata != s2_exp_q);

    // Two-stage pipeline lines up each read with its returning data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_exp_q     <= '0;
            s1_addr_q    <= '0;
            s1_elem_q    <= 3'd0;
            s2_valid_q   <= 1'b0;
            s2_exp_q     <= '0;
            s2_addr_q    <= '0;
            s2_elem_q    <= 3'd0;
            fail_q       <= 1'b0;
            fail_addr_q  <= '0;
            fail_elem_q  <= 3'd0;
            fail_count_q <= 8'd0;
        end else begin
            s1_valid_q <= (state_q == S_RUN) && !we_q;
            s1_exp_q   <= cur_exp_q;
            s1_addr_q  <= addr_q;
            s1_elem_q  <= cur_elem_q;
            s2_valid_q <= s1_valid_q;
            s2_exp_q   <= s1_exp_q;
            s2_addr_q  <= s1_addr_q;
            s2_elem_q  <= s1_elem_q;
            if (start_acc) begin
                fail_q       <= 1'b0;
                fail_addr_q  <= '0;
                fail_elem_q  <= 3'd0;
                fail_count_q <= 8'd0;
            end else if (miscompare) begin
                fail_q <= 1'b1;
                if (fail_count_q != 8'hFF) fail_count_q <= fail_count_q + 8'd1;
                if (!fail_q) begin
                    fail_addr_q <= s2_addr_q;
                    fail_elem_q <= s2_elem_q;
                end
            end
        end
    end

    assign mem_write_read = we_q;
    assign mem_address    = addr_q;
    assign mem_wdata      = wdata_q;
    assign busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done           = (state_q == S_DONE);
    assign fail           = fail_q;
    assign fail_addr      = fail_addr_q;
    assign fail_elem      = fail_elem_q;
    assign fail_count     = fail_count_q;

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Directed bench for march_bist_ctrl with a behavioural memory (registered
// wdata, 2-cycle read latency) and selectable injected faults.
module tb_march_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       mem_write_read;
    logic [3:0] mem_address;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy, done, fail;
    logic [3:0] fail_addr;
    logic [2:0] fail_elem;
    logic [7:0] fail_count;

    int checks = 0;
    int errors = 0;
    int fault_mode = 0;   // 0 none, 1 transition 4->5 bit2, 2 stuck-at-1 bit0 @9

    always #5 clk = ~clk;

    march_bist_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CAPACITY(15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_write_read(mem_write_read), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .fail(fail),
        .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_count(fail_count)
    );

    logic [7:0] mem [0:15];
    logic [7:0] wd_r, rd1;

    always @(posedge clk) begin
        wd_r      <= mem_wdata;
        rd1       <= (fault_mode == 2 && mem_address == 4'd9) ? (mem[mem_address] | 8'h01)
                                                              : mem[mem_address];
        mem_rdata <= rd1;
        if (mem_write_read) begin
            mem[mem_address] <= (fault_mode == 2 && mem_address == 4'd9) ? (wd_r | 8'h01) : wd_r;
            if (fault_mode == 1 && mem_address == 4'd4 && !mem[4][1] && wd_r[1])
                mem[5] <= mem[5] | 8'h04;
        end
    end

    // Reference op list for N=16.
    int         exp_we [0:159];
    int         exp_ad [0:159];
    logic [7:0] exp_d  [0:159];
    int         nops = 0;
    int         obs_we [0:200];
    int         obs_ad [0:200];
    int         obs_wd [0:200];

    task automatic add_op(input int we, input int ad, input logic [7:0] d);
        exp_we[nops] = we;
        exp_ad[nops] = ad;
        exp_d[nops]  = d;
        nops++;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_we"},    int'(mem_write_read), 0);
        chk({tag, "_addr"},  int'(mem_address), 0);
        chk({tag, "_wdata"}, int'(mem_wdata), 0);
        chk({tag, "_busy"},  int'(busy), 0);
        chk({tag, "_done"},  int'(done), 0);
        chk({tag, "_fail"},  int'(fail), 0);
        chk({tag, "_faddr"}, int'(fail_addr), 0);
        chk({tag, "_felem"}, int'(fail_elem), 0);
        chk({tag, "_fcnt"},  int'(fail_count), 0);
    endtask

    // exp_cnt < 0 means "at least one".
    task automatic run_check(input string tag, input int restart_at, input int exp_fail,
                             input int exp_faddr, input int exp_felem, input int exp_cnt);
        int done_cyc = -1;
        int op_err   = 0;
        int st_err   = 0;
        @(negedge clk);
        chk({tag, "_wdata_c0"}, int'(mem_wdata), 0);
        obs_wd[0] = int'(mem_wdata);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk({tag, "_clr_fail"}, int'(fail), 0);
        chk({tag, "_clr_done"}, int'(done), 0);
        for (int c = 1; c <= 200; c++) begin
            obs_we[c] = int'(mem_write_read);
            obs_ad[c] = int'(mem_address);
            obs_wd[c] = int'(mem_wdata);
            if (c <= 160)
                if (int'(mem_write_read) !== exp_we[c-1] || int'(mem_address) !== exp_ad[c-1])
                    op_err++;
            if (c <= 159 && exp_we[c] == 1 && mem_wdata !== exp_d[c]) op_err++;
            if (done) begin
                done_cyc = c;
                break;
            end
            if (busy !== 1'b1) st_err++;
            if (c == restart_at) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        chk({tag, "_done_cycle"}, done_cyc, 163);
        chk({tag, "_op_seq_errs"}, op_err, 0);
        chk({tag, "_busy_errs"}, st_err, 0);
        chk({tag, "_busy_at_done"}, int'(busy), 0);
        chk({tag, "_fail"}, int'(fail), exp_fail);
        chk({tag, "_fail_addr"}, int'(fail_addr), exp_faddr);
        chk({tag, "_fail_elem"}, int'(fail_elem), exp_felem);
        if (exp_cnt >= 0) begin
            chk({tag, "_fail_count"}, int'(fail_count), exp_cnt);
        end else begin
            checks++;
            assert (fail_count >= 8'd1) else begin
                errors++;
                $error("FAIL %s_fail_count observed=%0d expected>=1", tag, fail_count);
            end
        end
    endtask

    initial begin
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < 16; i++) begin
                int a;
                a = (e == 3 || e == 4) ? 15 - i : i;
                case (e)
                    0:       add_op(1, a, 8'h00);
                    1, 3:    begin add_op(0, a, 8'h00); add_op(1, a, 8'hFF); end
                    2, 4:    begin add_op(0, a, 8'hFF); add_op(1, a, 8'h00); end
                    default: add_op(0, a, 8'h00);
                endcase
            end
        end

        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // fault-free run
        fault_mode = 0;
        run_check("t1", 0, 0, 0, 0, 0);
        chk("t1_first_we",   obs_we[1], 1);
        chk("t1_first_addr", obs_ad[1], 0);
        chk("t1_first_wd",   obs_wd[0], 0);
        // e0 last w0@15 in cycle 16, e1 r0@0 in 17, first w1@0 in 18
        chk("t6_e0_last_we",  obs_we[16], 1);
        chk("t6_e0_last_ad",  obs_ad[16], 15);
        chk("t6_wd_before",   obs_wd[16], 8'h00);
        chk("t6_wd_switch",   obs_wd[17], 8'hFF);
        chk("t6_first_w1_we", obs_we[18], 1);
        chk("t6_first_w1_ad", obs_ad[18], 0);
        // e2 last w0@15 in cycle 80, e3 first r0@15 in cycle 81
        chk("t6_e2_last_we",  obs_we[80], 1);
        chk("t6_e2_last_ad",  obs_ad[80], 15);
        chk("t6_e3_first_we", obs_we[81], 0);
        chk("t6_e3_first_ad", obs_ad[81], 15);

        fault_mode = 1;
        run_check("t2", 0, 1, 5, 1, -1);

        fault_mode = 2;
        run_check("t3", 0, 1, 9, 1, 3);

        // restart from DONE clears previous failure; start mid-run ignored
        fault_mode = 0;
        run_check("t4", 80, 0, 0, 0, 0);

        // reset in the middle of a failing run
        fault_mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        chk("t5_fail_before_rst", int'(fail), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("t5_in_reset");
        @(posedge clk);
        @(negedge clk);
        chk("t5_busy_held", int'(busy), 0);
        rst_n = 1'b1;
        run_check("t5", 0, 1, 9, 1, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
